result_streamer: RTL and testbench
==================================

// Module: result_streamer
// PURPOSE
//   Drains the per-PE popcount results held by the accelerator top after a compute pass.
//   Sits downstream of the systolic top and takes in results_flat (NUM_PES x RES_W) when done rises.
//   Serialises that snapshot into OUT_W-bit words on a valid/ready stream toward the host/DMA.
//   Flags frames lost because a new done arrived while a drain was in progress.
// PARAMETERS
//   NUM_PES  64  number of PE results per frame
//   RES_W    16  width of one PE result
//   OUT_W    64  stream word width; NUM_PES*RES_W must be a multiple of OUT_W
//   WORDS    NUM_PES*RES_W/OUT_W (derived, default 16); IDX_W = $clog2(WORDS) (default 4)
// PORTS
//   clk            in   1                clock, all logic on rising edge
//   reset_n        in   1                synchronous, active-low reset
//   done_in        in   1                accelerator done level; rising edge = frame ready
//   results_in     in   NUM_PES*RES_W    result vector, stable while done_in high
//   m_valid        out  1                stream word valid
//   m_ready        in   1                downstream accepts word when m_valid&m_ready
//   m_data         out  OUT_W            stream word
//   m_idx          out  IDX_W            index of current word within frame
//   m_last         out  1                high with word WORDS-1
//   busy           out  1                high while in S_STREAM
//   frame_cnt      out  8                frames fully drained, wraps 255->0
//   overrun        out  1                sticky: done edge seen while busy (frame dropped)
//   clear_overrun  in   1                clears overrun
// BEHAVIOUR
//   Reset (reset_n=0 at a clk edge): m_valid=0, m_idx=0, m_last=0, busy=0, frame_cnt=0,
//     overrun=0, done_q=0, state=S_IDLE; m_data=0. Buffer contents don't-care.
//   Edge detect: done_q<=done_in each cycle; edge = done_in & ~done_q.
//   Reset mid-stream: frame abandoned, no m_last; a done_in already high after reset
//     counts as an edge (done_q=0).
//   S_IDLE: on edge, register results_in into buf, m_idx<=0, go S_STREAM.
//     m_valid=1 from the following cycle (1-cycle latency edge->first word).
//   S_STREAM: m_data = buf[m_idx*OUT_W +: OUT_W] (word 0 = PE0..PE3, PE0 in bits [15:0]).
//     Handshake when m_valid&m_ready: m_idx++.
//     m_valid=1 and !m_ready: m_data, m_idx and m_last held stable.
//     m_last = (m_idx==WORDS-1), combinational from m_idx.
//     Handshake on last word: frame_cnt++, then
//       if edge in the same cycle: capture new frame, stay S_STREAM, m_idx<=0 (no bubble);
//       else go S_IDLE, m_valid=0 next cycle.
//   Edge while S_STREAM and not on the final handshake: frame ignored, buf untouched,
//     overrun<=1.
//   overrun: set has priority over clear_overrun in the same cycle.
//   m_valid never depends combinationally on m_ready.
//   Arithmetic: m_idx wraps at WORDS-1 only via return to 0 on capture; frame_cnt mod 256.
// STRUCTURE
//   Shared package bnn_pkg:
//     RES_W, OUT_W localparams;
//     function words(num_pes, res_w, out_w);
//     typedef enum logic {S_IDLE, S_STREAM} stream_state_t.
//   Single module, no sub-modules.
//   Elaboration check: $error if (NUM_PES*RES_W) % OUT_W != 0.
//   Registers: done_q, state, buf, m_idx, frame_cnt, overrun.
// TESTING
//   1 Basic drain: results_in PE k = k (16'hk), done_in rises, m_ready=1 ->
//     16 words, one per cycle starting 1 cycle after edge.
//     Word0 = 64'h0003_0002_0001_0000; m_last only on m_idx=15; frame_cnt=1; busy low after.
//   2 Backpressure: m_ready toggled pseudo-random (~30% high) ->
//     m_data/m_idx stable during every stall; all 16 words in order; no duplicates.
//   3 Overrun: done_in pulses again while m_idx=5 ->
//     overrun=1 and stays 1; words 5..15 are still the first frame.
//     clear_overrun=1 for 1 cycle -> overrun=0.
//   4 Back-to-back: second done edge on the same cycle as the word-15 handshake ->
//     next cycle m_valid=1, m_idx=0, new frame data; overrun stays 0; frame_cnt=1 then 2.
//   5 Reset mid-stream: reset_n low 1 cycle at m_idx=7 ->
//     next cycle m_valid=0, frame_cnt=0, overrun=0.
//     done_in still high -> new drain from word 0.
//   6 Level hold and wrap: done_in held high 100 cycles -> exactly one frame;
//     256 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared constants and types for the BNN accelerator result path.
package bnn_pkg;

    localparam int RES_W = 16;
    localparam int OUT_W = 64;

    function automatic int words(input int num_pes, input int res_w, input int out_w);
        return (num_pes * res_w) / out_w;
    endfunction

    typedef enum logic {S_IDLE, S_STREAM} stream_state_t;

endpackage

// File: rtl/result_streamer.sv
// Snapshots the per-PE popcount vector on a rising done edge and drains it as
// OUT_W-bit words on a valid/ready stream, flagging frames dropped mid-drain.
module result_streamer
    import bnn_pkg::*;
#(
    parameter int NUM_PES = 64,
    parameter int RES_W   = bnn_pkg::RES_W,
    parameter int OUT_W   = bnn_pkg::OUT_W,
    parameter int WORDS   = words(NUM_PES, RES_W, OUT_W),
    parameter int IDX_W   = $clog2(WORDS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     done_in,
    input  logic [NUM_PES*RES_W-1:0] results_in,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [OUT_W-1:0]         m_data,
    output logic [IDX_W-1:0]         m_idx,
    output logic                     m_last,
    output logic                     busy,
    output logic [7:0]               frame_cnt,
    output logic                     overrun,
    input  logic                     clear_overrun
);

    localparam int TOT_W = NUM_PES * RES_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    if ((TOT_W % OUT_W) != 0) begin : g_width_check
        $error("result_streamer: NUM_PES*RES_W must be a multiple of OUT_W");
    end

    stream_state_t      state;
    logic               done_q;
    logic [TOT_W-1:0]   res_buf;
    logic               edge_det;
    logic               hs;
    logic               last_hs;

    // Stream contract: a word transfers on any rising edge where m_valid and
    // m_ready are both high; once m_valid is up, m_data/m_idx/m_last hold until
    // that transfer, and m_valid is a pure function of registered state.
    assign edge_det = done_in & ~done_q;
    assign m_valid  = (state == S_STREAM);
    assign busy     = (state == S_STREAM);
    assign hs       = m_valid & m_ready;
    assign m_last   = m_valid && (m_idx == LAST_IDX);
    assign last_hs  = hs & m_last;
    assign m_data   = m_valid ? res_buf[int'(m_idx)*OUT_W +: OUT_W] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            done_q    <= 1'b0;
            m_idx     <= '0;
            frame_cnt <= 8'd0;
            overrun   <= 1'b0;
        end else begin
            done_q <= done_in;
            case (state)
                S_IDLE: begin
                    if (edge_det) begin
                        res_buf <= results_in;
                        m_idx   <= '0;
                        state   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (hs) begin
                        if (m_last) begin
                            frame_cnt <= frame_cnt + 8'd1;
                            m_idx     <= '0;
                            // A done edge landing on the final handshake chains straight into the next frame.
                            if (edge_det) begin
                                res_buf <= results_in;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            m_idx <= m_idx + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (edge_det && (state == S_STREAM) && !last_hs) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: drain, backpressure, overrun, chaining,
// mid-stream reset, level-held done and frame counter wrap.
module tb_result_streamer;

    localparam int NUM_PES = 64;
    localparam int RES_W   = 16;
    localparam int OUT_W   = 64;
    localparam int WORDS   = 16;
    localparam int TOT_W   = NUM_PES * RES_W;

    logic             clk;
    logic             reset_n;
    logic             done_in;
    logic [TOT_W-1:0] results_in;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_data;
    logic [3:0]       m_idx;
    logic             m_last;
    logic             busy;
    logic [7:0]       frame_cnt;
    logic             overrun;
    logic             clear_overrun;

    logic [OUT_W-1:0] exp_q[$];
    logic [3:0]       exp_idx_q[$];
    int               n_checks;
    int               n_errors;
    int               exp_frames;
    int               last_cycles;

    result_streamer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .done_in       (done_in),
        .results_in    (results_in),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_idx         (m_idx),
        .m_last        (m_last),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TOT_W-1:0] make_frame(input logic [15:0] base);
        logic [TOT_W-1:0] v;
        for (int k = 0; k < NUM_PES; k++) v[k*RES_W +: RES_W] = base + 16'(k);
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] exp_word(input logic [15:0] base, input int w);
        logic [OUT_W-1:0] d;
        for (int j = 0; j < 4; j++) d[j*16 +: 16] = base + 16'(4*w + j);
        return d;
    endfunction

    task automatic push_frame(input logic [15:0] base);
        for (int w = 0; w < WORDS; w++) begin
            exp_q.push_back(exp_word(base, w));
            exp_idx_q.push_back(4'(w));
        end
    endtask

    // Checks outputs for the upcoming edge given the m_ready already driven.
    task automatic observe();
        if (exp_q.size() == 0) begin
            chk("idle_valid", {63'd0, m_valid}, 64'd0);
            chk("idle_last", {63'd0, m_last}, 64'd0);
        end else begin
            chk("valid", {63'd0, m_valid}, 64'd1);
            chk("busy", {63'd0, busy}, 64'd1);
            if (m_valid) begin
                chk("data", m_data, exp_q[0]);
                chk("idx", {60'd0, m_idx}, {60'd0, exp_idx_q[0]});
                chk("last", {63'd0, m_last}, {63'd0, exp_idx_q[0] == 4'd15});
                if (m_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_idx_q.pop_front());
                end
            end
        end
    endtask

    task automatic drain(input string tag, input int pct, input int budget);
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            m_ready = ($urandom_range(0, 99) < pct);
            observe();
            tick();
            cyc++;
        end
        last_cycles = cyc;
        if (exp_q.size() != 0) chk({tag, "_timeout"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic start_frame(input logic [15:0] base);
        results_in = make_frame(base);
        push_frame(base);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
    endtask

    initial begin
        int cyc;
        bit sent;
        n_checks = 0;
        n_errors = 0;
        exp_frames = 0;
        reset_n = 1'b0;
        done_in = 1'b0;
        results_in = '0;
        m_ready = 1'b0;
        clear_overrun = 1'b0;
        repeat (3) tick();

        chk("rst_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_idx", {60'd0, m_idx}, 64'd0);
        chk("rst_last", {63'd0, m_last}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_frame_cnt", {56'd0, frame_cnt}, 64'd0);
        chk("rst_overrun", {63'd0, overrun}, 64'd0);
        chk("rst_data", m_data, 64'd0);
        reset_n = 1'b1;
        tick();

        // Basic drain, PE k = k
        m_ready = 1'b1;
        start_frame(16'h0000);
        chk("t1_latency_valid", {63'd0, m_valid}, 64'd1);
        chk("t1_word0", m_data, 64'h0003_0002_0001_0000);
        drain("t1", 100, 40);
        exp_frames++;
        chk("t1_cycles", 64'(last_cycles), 64'd16);
        chk("t1_busy_after", {63'd0, busy}, 64'd0);
        chk("t1_valid_after", {63'd0, m_valid}, 64'd0);
        chk("t1_frame_cnt", {56'd0, frame_cnt}, 64'd1);

        // Backpressure, ~30% ready
        start_frame(16'h1000);
        drain("t2", 30, 1000);
        exp_frames++;
        chk("t2_frame_cnt", {56'd0, frame_cnt}, 64'(exp_frames));

        // Overrun at word 5; remaining words must be the first frame
        m_ready = 1'b1;
        start_frame(16'h2000);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            m_ready = 1'b1;
            done_in = m_valid && (m_idx == 4'd5);
            if (done_in) results_in = make_frame(16'h3000);
            observe();
            tick();
            done_in = 1'b0;
            cyc++;
        end
        if (exp_q.size() != 0) chk("t3_timeout", 64'(exp_q.size()), 64'd0);
        exp_frames++;
        chk("t3_overrun_set", {63'd0, overrun}, 64'd1);
        chk("t3_frame_cnt", {56'd0, frame_cnt}, 64'(exp_frames));
        repeat (3) tick();
        chk("t3_overrun_sticky", {63'd0, overrun}, 64'd1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("t3_overrun_clear", {63'd0, overrun}, 64'd0);

        // Back-to-back: new edge on the word-15 handshake
        start_frame(16'h4000);
        cyc = 0;
        sent = 1'b0;
        while (exp_q.size() > 0 && cyc < 60) begin
            m_ready = 1'b1;
            if (!sent && m_valid && m_idx == 4'd15) begin
                done_in = 1'b1;
                results_in = make_frame(16'h5000);
                push_frame(16'h5000);
                sent = 1'b1;
                observe();
                tick();
                done_in = 1'b0;
                exp_frames++;
                chk("t4_no_bubble", {63'd0, m_valid}, 64'd1);
                chk("t4_idx0", {60'd0, m_idx}, 64'd0);
                chk("t4_frame_cnt_a", {56'd0, frame_cnt}, 64'(exp_frames));
            end else begin
                observe();
                tick();
            end
            cyc++;
        end
        if (exp_q.size() != 0) chk("t4_timeout", 64'(exp_q.size()), 64'd0);
        exp_frames++;
        chk("t4_frame_cnt_b", {56'd0, frame_cnt}, 64'(exp_frames));
        chk("t4_overrun", {63'd0, overrun}, 64'd0);

        // Reset at word 7 with done_in held high
        results_in = make_frame(16'h6000);
        push_frame(16'h6000);
        done_in = 1'b1;
        tick();
        cyc = 0;
        while (cyc < 40 && !(m_valid && m_idx == 4'd7)) begin
            m_ready = 1'b1;
            observe();
            tick();
            cyc++;
        end
        chk("t5_reached_idx7", {60'd0, m_idx}, 64'd7);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_q.delete();
        exp_idx_q.delete();
        exp_frames = 0;
        chk("t5_valid", {63'd0, m_valid}, 64'd0);
        chk("t5_frame_cnt", {56'd0, frame_cnt}, 64'd0);
        chk("t5_overrun", {63'd0, overrun}, 64'd0);
        push_frame(16'h6000);
        tick();
        chk("t5_restart_valid", {63'd0, m_valid}, 64'd1);
        chk("t5_restart_idx", {60'd0, m_idx}, 64'd0);
        drain("t5", 100, 40);
        exp_frames++;

        // Level hold: done_in stays high, no further frames
        for (int i = 0; i < 100; i++) begin
            m_ready = 1'b1;
            observe();
            tick();
        end
        chk("t6_hold_frame_cnt", {56'd0, frame_cnt}, 64'd1);
        done_in = 1'b0;
        tick();

        // Wrap: 255 more frames brings the count back to 0
        for (int f = 0; f < 255; f++) begin
            m_ready = 1'b1;
            start_frame(16'(f * 7 + 16'h0100));
            drain("t6_wrap", 100, 40);
            exp_frames++;
            if (f == 253) chk("t6_frame_cnt_255", {56'd0, frame_cnt}, 64'd255);
        end
        chk("t6_frame_cnt_wrap", {56'd0, frame_cnt}, 64'(exp_frames % 256));
        chk("t6_idle", {63'd0, busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
